// File: rtl/ast_send_mc.sv
// Multi-channel alarm/strobe generator: per-channel pulse FSM with manual and
// ADC threshold-crossing triggers, microsecond width/holdoff, fx register bus.
module ast_send_mc_ch #(
  parameter int AD_W  = 16,
  parameter int CNT_W = 8
) (
  input  logic            clk_sys,
  input  logic            rst_n,
  input  logic            pluse_us,
  input  logic [AD_W-1:0] ad_data,
  input  logic            ad_vld,
  input  logic            wr,
  input  logic [2:0]      woff,
  input  logic [7:0]      wdata,
  input  logic [2:0]      roff,
  output logic [7:0]      rdata,
  output logic            ast
);
  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

  state_t          state;
  logic            pol;
  logic [CNT_W-1:0] width, holdoff, cnt, hold_lat, wlen;
  logic [2:0]      mode;
  logic [15:0]     thr;
  logic            ovr, prev_ok;
  logic [AD_W-1:0] prev, thr_c;
  logic            rise, fall, man, aut, trig, pol_n;

  assign thr_c = AD_W'(thr);
  assign rise  = prev_ok && (prev <  thr_c) && (ad_data >= thr_c);
  assign fall  = prev_ok && (prev >= thr_c) && (ad_data <  thr_c);
  assign man   = wr && (woff == 3'd6) && wdata[0] && mode[0];
  assign aut   = mode[1] && ad_vld && (mode[2] ? fall : rise);
  // manual and auto in the same cycle collapse into a single trigger
  assign trig  = man | aut;
  assign wlen  = (width == '0) ? CNT_W'(1) : width;
  // polarity is live: a write this cycle already shapes the next output
  assign pol_n = (wr && woff == 3'd0) ? wdata[0] : pol;

  always_comb begin
    rdata = '0;
    case (roff)
      3'd0: rdata = {7'd0, pol};
      3'd1: rdata = 8'(width);
      3'd2: rdata = {5'd0, mode};
      3'd3: rdata = thr[7:0];
      3'd4: rdata = thr[15:8];
      3'd5: rdata = 8'(holdoff);
      3'd7: rdata = {6'd0, ovr, state != IDLE};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0; hold_lat <= '0;
      pol <= 1'b1; width <= CNT_W'(1); mode <= 3'b001;
      thr <= 16'h8000; holdoff <= '0;
      ovr <= 1'b0; prev <= '0; prev_ok <= 1'b0;
      ast <= 1'b0;
    end else begin
      if (wr) begin
        case (woff)
          3'd0: pol     <= wdata[0];
          3'd1: width   <= CNT_W'(wdata);
          3'd2: mode    <= wdata[2:0];
          3'd3: thr[7:0]  <= wdata;
          3'd4: thr[15:8] <= wdata;
          3'd5: holdoff <= CNT_W'(wdata);
          default: ;
        endcase
      end
      if (ad_vld) prev <= ad_data;
      if (wr && (woff == 3'd3 || woff == 3'd4)) prev_ok <= 1'b0;
      else if (ad_vld)                          prev_ok <= 1'b1;
      if (trig && state != IDLE)          ovr <= 1'b1;
      else if (wr && woff == 3'd7)        ovr <= 1'b0;

      case (state)
        IDLE: begin
          ast <= ~pol_n;
          if (trig) begin
            state    <= PULSE;
            cnt      <= wlen;
            hold_lat <= holdoff;
            ast      <= pol_n;
          end
        end
        PULSE: begin
          ast <= pol_n;
          if (pluse_us) begin
            if (cnt == CNT_W'(1)) begin
              ast <= ~pol_n;
              if (hold_lat != '0) begin
                state <= HOLD;
                cnt   <= hold_lat;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        HOLD: begin
          ast <= ~pol_n;
          if (pluse_us) begin
            if (cnt == CNT_W'(1)) state <= IDLE;
            else                  cnt   <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          ast   <= ~pol_n;
        end
      endcase
    end
  end
endmodule

module ast_send_mc #(
  parameter int CH_NUM = 4,
  parameter int AD_W   = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              pluse_us,
  input  logic [5:0]        dev_id,
  input  logic [AD_W-1:0]   ad_data,
  input  logic              ad_vld,
  input  logic [21:0]       fx_waddr,
  input  logic              fx_wr,
  input  logic [7:0]        fx_data,
  input  logic [21:0]       fx_raddr,
  input  logic              fx_rd,
  output logic [7:0]        fx_q,
  output logic [CH_NUM-1:0] ast
);
  logic                   hit_w, hit_r;
  logic [4:0]             wch, rch;
  logic [CH_NUM-1:0]      wr_ch;
  logic [CH_NUM-1:0][7:0] rdata;
  logic [7:0]             rd_mux;

  assign hit_w = (fx_waddr[21:16] == dev_id) && (fx_waddr[15:8] == 8'd0);
  assign hit_r = (fx_raddr[21:16] == dev_id) && (fx_raddr[15:8] == 8'd0);
  assign wch   = fx_waddr[7:3];
  assign rch   = fx_raddr[7:3];

  genvar i;
  generate
    for (i = 0; i < CH_NUM; i++) begin : g_ch
      assign wr_ch[i] = fx_wr && hit_w && (wch == 5'(i));
      ast_send_mc_ch #(.AD_W(AD_W), .CNT_W(CNT_W)) u_ch (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .pluse_us(pluse_us),
        .ad_data (ad_data),
        .ad_vld  (ad_vld),
        .wr      (wr_ch[i]),
        .woff    (fx_waddr[2:0]),
        .wdata   (fx_data),
        .roff    (fx_raddr[2:0]),
        .rdata   (rdata[i]),
        .ast     (ast[i])
      );
    end
  endgenerate

  // channels at or above CH_NUM match no lane and read back as zero
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < CH_NUM; k++)
      if (rch == 5'(k)) rd_mux = rdata[k];
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n)               fx_q <= '0;
    else if (fx_rd && hit_r)  fx_q <= rd_mux;
    else                      fx_q <= '0;
  end
endmodule

// File: tb/tb_ast_send_mc.sv
// Directed bench for ast_send_mc: expectations queued as stimulus is applied,
// popped and asserted when the DUT output is sampled.
module tb_ast_send_mc;
  localparam int CH_NUM = 4, AD_W = 16, CNT_W = 8;

  logic              clk_sys = 0, rst_n = 0, pluse_us = 0, ad_vld = 0;
  logic              fx_wr = 0, fx_rd = 0;
  logic [5:0]        dev_id = 6'd5;
  logic [AD_W-1:0]   ad_data = '0;
  logic [21:0]       fx_waddr = '0, fx_raddr = '0;
  logic [7:0]        fx_data = '0, fx_q;
  logic [CH_NUM-1:0] ast;

  typedef struct {string tag; logic [31:0] exp;} sb_t;
  sb_t sb[$];
  int n_chk = 0, n_fail = 0, us_seen = 0, div = 0;

  ast_send_mc #(.CH_NUM(CH_NUM), .AD_W(AD_W), .CNT_W(CNT_W)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .pluse_us(pluse_us), .dev_id(dev_id),
    .ad_data(ad_data), .ad_vld(ad_vld), .fx_waddr(fx_waddr), .fx_wr(fx_wr),
    .fx_data(fx_data), .fx_raddr(fx_raddr), .fx_rd(fx_rd), .fx_q(fx_q), .ast(ast)
  );

  initial forever #5 clk_sys = ~clk_sys;

  // one-cycle strobe every 100 clocks
  initial forever begin
    @(posedge clk_sys); #1;
    div = (div == 99) ? 0 : div + 1;
    pluse_us = (div == 99);
  end

  always @(posedge clk_sys) if (pluse_us) us_seen <= us_seen + 1;

  function automatic logic [21:0] adr(int ch, int off);
    return {dev_id, 8'h00, 5'(ch), 3'(off)};
  endfunction

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  task automatic push(string tag, logic [31:0] exp);
    sb.push_back('{tag, exp});
  endtask

  task automatic check(logic [31:0] obs);
    sb_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty observed=%h", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic wr(int ch, int off, logic [7:0] d);
    fx_waddr = adr(ch, off); fx_data = d; fx_wr = 1;
    tick();
    fx_wr = 0;
  endtask

  task automatic rd_raw(logic [21:0] a, logic [7:0] exp, string tag);
    fx_raddr = a; fx_rd = 1;
    push(tag, {24'd0, exp});
    tick();
    fx_rd = 0;
    check({24'd0, fx_q});
  endtask

  task automatic rd(int ch, int off, logic [7:0] exp, string tag);
    rd_raw(adr(ch, off), exp, tag);
  endtask

  task automatic sample(logic [AD_W-1:0] d);
    ad_data = d; ad_vld = 1;
    tick();
    ad_vld = 0;
  endtask

  task automatic chk_ast(logic [CH_NUM-1:0] exp, string tag);
    push(tag, 32'(exp));
    check(32'(ast));
  endtask

  // wait until n strobes past base; ast must hold 'hold' until the last one
  task automatic wait_us(int base, int n, logic [CH_NUM-1:0] hold, string tag);
    int k = 0;
    logic bad = 0, tmo;
    while ((us_seen - base) < n && k < 2000) begin
      tick(); k++;
      if ((us_seen - base) < n && ast !== hold) bad = 1;
    end
    tmo = (us_seen - base) < n;
    push(tag, 32'd0);
    check({30'd0, tmo, bad});
  endtask

  initial begin
    int s0;
    longint t0, cyc;

    // 1: reset values and register defaults
    repeat (3) tick();
    chk_ast('0, "rst_ast");
    push("rst_fxq", 0); check({24'd0, fx_q});
    rst_n = 1; tick();
    rd(0, 0, 8'h01, "ch0_pol");
    rd(0, 1, 8'h01, "ch0_width");
    rd(0, 2, 8'h01, "ch0_mode");
    rd(0, 3, 8'h00, "ch0_thr_lo");
    rd(0, 4, 8'h80, "ch0_thr_hi");
    rd(0, 7, 8'h00, "ch0_status");
    rd(CH_NUM, 0, 8'h00, "unmapped_ch");
    rd_raw({6'd6, 8'h00, 5'd0, 3'd0}, 8'h00, "wrong_dev");

    // 2: manual pulse on ch1, width 3
    wr(1, 1, 8'd3); wr(1, 5, 8'd0);
    chk_ast(4'b0000, "t2_idle");
    wr(1, 6, 8'h01);
    s0 = us_seen; t0 = $time;
    chk_ast(4'b0010, "t2_rise");
    rd(1, 7, 8'h01, "t2_busy");
    wait_us(s0, 3, 4'b0010, "t2_pulse_hold");
    chk_ast(4'b0000, "t2_fall");
    cyc = ($time - t0) / 10;
    push("t2_width_cycles", 1); check({31'd0, (cyc >= 200 && cyc <= 301)});

    // 3: auto trigger on ch2, active-low
    wr(2, 0, 8'h00);
    chk_ast(4'b0100, "t3_pol0_idle");
    wr(2, 2, 8'h02); wr(2, 3, 8'h00); wr(2, 4, 8'h10);
    sample(16'h0800);
    chk_ast(4'b0100, "t3_below_thr");
    sample(16'h1000);
    s0 = us_seen;
    chk_ast(4'b0000, "t3_rise_fire");
    wait_us(s0, 1, 4'b0000, "t3_rise_pulse");
    chk_ast(4'b0100, "t3_rise_end");
    wr(2, 2, 8'h06);
    sample(16'h1000);
    chk_ast(4'b0100, "t3_no_fall");
    sample(16'h0FFF);
    s0 = us_seen;
    chk_ast(4'b0000, "t3_fall_fire");
    wait_us(s0, 1, 4'b0000, "t3_fall_pulse");
    chk_ast(4'b0100, "t3_fall_end");
    wr(2, 3, 8'h00); wr(2, 2, 8'h02);
    sample(16'h1000);
    chk_ast(4'b0100, "t3_prev_ok_clr");

    // 4: holdoff and overrun on ch0
    wr(0, 1, 8'd2); wr(0, 5, 8'd5);
    wr(0, 6, 8'h01);
    s0 = us_seen;
    chk_ast(4'b0101, "t4_rise");
    wait_us(s0, 2, 4'b0101, "t4_pulse");
    chk_ast(4'b0100, "t4_in_hold");
    wait_us(s0, 3, 4'b0100, "t4_hold_a");
    wr(0, 6, 8'h01);
    chk_ast(4'b0100, "t4_no_retrig");
    rd(0, 7, 8'h03, "t4_overrun");
    wr(0, 7, 8'h00);
    rd(0, 7, 8'h01, "t4_ovr_clr");
    wait_us(s0, 7, 4'b0100, "t4_hold_b");
    rd(0, 7, 8'h00, "t4_idle");

    // 5: manual and auto together on ch3
    wr(3, 2, 8'h03);
    sample(16'h7000);
    fx_waddr = adr(3, 6); fx_data = 8'h01; fx_wr = 1;
    ad_data = 16'h9000; ad_vld = 1;
    tick();
    fx_wr = 0; ad_vld = 0;
    s0 = us_seen;
    chk_ast(4'b1100, "t5_fire");
    wait_us(s0, 1, 4'b1100, "t5_pulse");
    chk_ast(4'b0100, "t5_end");
    rd(3, 7, 8'h00, "t5_no_overrun");

    // 6: reset mid-pulse on ch1
    wr(1, 6, 8'h01);
    chk_ast(4'b0110, "t6_rise");
    repeat (3) tick();
    rst_n = 0; tick();
    chk_ast(4'b0000, "t6_rst_next");
    tick(); tick();
    chk_ast(4'b0000, "t6_rst_hold");
    rst_n = 1; tick();
    rd(1, 1, 8'h01, "t6_width_rst");
    wait_us(us_seen, 4, 4'b0000, "t6_no_residual");
    chk_ast(4'b0000, "t6_quiet");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ast_send_mc.md
Name: ast_send_mc

Overview:
- Multi-channel, parametrised successor to the single-output alarm/strobe generator.
- Drives CH_NUM independent pulse outputs.
- Each channel is triggered by a register command (manual mode) and/or by an ADC sample crossing a per-channel threshold (auto mode).
- Pulse width and post-pulse holdoff are programmable in microseconds. Overrun of a busy channel is reported.
- Sits on the fx register bus beside the other device blocks, selected by dev_id.

Parameters:
CH_NUM, 4, number of ast channels (1..32)
AD_W, 16, ADC sample width
CNT_W, 8, width/holdoff counter width in us units

Ports:
clk_sys  in  1  system clock, single clock domain
rst_n  in  1  synchronous active-low reset
pluse_us  in  1  one-cycle strobe every microsecond
dev_id  in  6  device id for fx address decode
ad_data  in  AD_W  ADC sample, unsigned
ad_vld  in  1  ad_data valid strobe
fx_waddr  in  22  write address
fx_wr  in  1  write strobe
fx_data  in  8  write data
fx_raddr  in  22  read address
fx_rd  in  1  read strobe
fx_q  out  8  read data
ast  out  CH_NUM  pulse outputs, one bit per channel

Behaviour:
- Reset is synchronous and active-low on rst_n, sampled at the clk_sys rising edge. All state updates occur on clk_sys rising edges.
- Address decode: a block hit requires addr[21:16]==dev_id and addr[15:8]==0. Channel = addr[7:3]; off = addr[2:0]. A channel >= CH_NUM is unmapped: writes are ignored, reads return 0.
- Per-channel registers:
  - off0 cfg_pol: bit0, 1 = active-high. Reset 1.
  - off1 cfg_width: pulse width in us; 0 is treated as 1. Reset 1.
  - off2 cfg_mode: bit0 manual enable, bit1 auto enable, bit2 edge (0 = rising, 1 = falling). Reset 0x01.
  - off3 thr_lo, off4 thr_hi: threshold[15:0]. Reset 0x8000. When AD_W<16, the low AD_W bits are used.
  - off5 holdoff: us after the pulse during which triggers are rejected. Reset 0.
  - off6 cmd: writing with bit0=1 produces a one-cycle manual trigger. Write-only; reads 0.
  - off7 status (read): bit0 busy (PULSE or HOLD), bit1 overrun (sticky). Any write to off7 clears overrun.
- Reads: fx_q is registered with 1-cycle latency after fx_rd. When fx_rd is low or the address misses, fx_q=0 on the next cycle. Reset value of fx_q is 0.
- Manual trigger: a cmd write with bit0=1 while mode bit0=1.
- Auto trigger:
  - Active only while mode bit1=1.
  - On each ad_vld the sample is registered as prev, and prev_ok is set.
  - Rising trigger: prev_ok && prev < thr && ad_data >= thr.
  - Falling trigger: prev_ok && prev >= thr && ad_data < thr.
  - prev_ok is cleared by reset and on any write to thr_lo or thr_hi.
  - All comparisons are unsigned.
- trig = manual | auto. If both occur in the same cycle, only one trigger is taken.
- FSM per channel: IDLE, PULSE, HOLD.
  - IDLE + trig: enter PULSE next cycle. Latch cnt = max(cfg_width,1) and the current holdoff.
  - PULSE: decrement cnt on each pluse_us. At cnt==1 with pluse_us, go to HOLD if latched holdoff != 0 (cnt = holdoff), else go to IDLE.
  - HOLD: decrement on each pluse_us. At cnt==1 with pluse_us, go to IDLE.
  - trig in PULSE or HOLD: trigger is dropped and overrun is set. If the overrun-clear write and a new overrun happen in the same cycle, set wins.
- Output: ast[i] = (state==PULSE) ? cfg_pol : ~cfg_pol. This is registered and goes active the cycle after trig.
- Pulse duration is the count of pluse_us strobes, so actual width is between W-1 and W us plus one cycle, depending on the strobe phase.
- Config writes during PULSE or HOLD do not affect the running count. cfg_pol is not latched and takes effect immediately.
- Reset mid-pulse: FSM returns to IDLE and all registers reset. ast becomes all 0 the cycle after reset is sampled and holds 0 while rst_n=0.
- Channels are fully independent; simultaneous triggers on several channels are all serviced.
- Reset values: ast=0, fx_q=0, all FSMs IDLE, overrun=0, prev_ok=0.

Test Plan:
1. Reset, then read ch0 off1, off2, off3, off4 with dev_id=5 -> fx_q = 0x01, 0x01, 0x00, 0x80. Read ch CH_NUM off0 -> 0.
2. ch1: width=3, holdoff=0, pol=1; write cmd=1 -> ast[1] rises the next cycle, falls after the 3rd pluse_us (pluse_us period 100 cycles), status busy=1 during the pulse, and no other ast bit toggles.
3. ch2: pol=0, mode=0x02, thr=0x1000; feed ad_data 0x0800 then 0x1000 with ad_vld -> ast[2] goes low for width us. Repeat with the falling-edge mode bit set -> ast[2] fires on 0x1000 followed by 0x0FFF.
4. ch0: width=2, holdoff=5; cmd at t0, second cmd 3 us later -> only one pulse; status=0x03. Write off7 -> status=0x01 while still in HOLD, 0x00 after HOLD ends.
5. Manual cmd and auto crossing in the same cycle on ch3 -> exactly one pulse, overrun=0.
6. Assert rst_n=0 mid-pulse on ch1 -> ast=0 on the next clock. Release reset -> cfg_width reads 0x01 and no residual pulse appears.
